// File: rtl/spi_cmd_pkg.sv
// Shared constants and FSM state type for the PLL-board SPI command master.
package spi_cmd_pkg;

  localparam int CMD_BIT_NUM   = 41;
  localparam int REPLY_BIT_NUM = 6;
  localparam int OPCODE_BITS   = 4;
  localparam logic [OPCODE_BITS-1:0] READ_OPCODE = 4'b1000;

  // Write frames carry a leading pad bit, so the shifter is one wider than a command.
  localparam int SHIFT_W   = CMD_BIT_NUM + 1;
  localparam int BIT_CNT_W = 6;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    LOW,
    HIGH,
    TAIL,
    CS_HOLD,
    CS_GAP
  } spi_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_cmd_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module spi_cmd_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;

  // NOTE: combinational blocks assign every output a default first so no path
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/spi_cmd_master.sv
// SPI initiator for the PLL-board command link: 42-clock write frames and
// 10-clock status-read frames with a 6-bit LSB-first lock reply.
module spi_cmd_master
  import spi_cmd_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int CS_HOLD_CYC = 16,
  parameter int CS_IDLE_CYC = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  input  logic                     req_read,
  input  logic [CMD_BIT_NUM-1:0]   req_data,
  output logic                     req_ready,
  output logic [REPLY_BIT_NUM-1:0] lock_status,
  output logic                     lock_valid,
  output logic                     busy,
  output logic                     spi_clk,
  output logic                     spi_cs,
  output logic                     spi_mosi,
  input  logic                     spi_miso
);

  localparam int TW = $clog2(max3(CLK_DIV, CS_HOLD_CYC, CS_IDLE_CYC) + 1);
  localparam logic [BIT_CNT_W-1:0] WRITE_LAST  = BIT_CNT_W'(CMD_BIT_NUM + 1);
  localparam logic [BIT_CNT_W-1:0] READ_LAST   = BIT_CNT_W'(OPCODE_BITS + REPLY_BIT_NUM);
  localparam logic [BIT_CNT_W-1:0] REPLY_START = BIT_CNT_W'(OPCODE_BITS);

  spi_state_e                 state_q, state_d;
  logic [BIT_CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic                       read_q, read_d;
  logic [SHIFT_W-1:0]         shreg_q, shreg_d;
  logic [REPLY_BIT_NUM-1:0]   reply_q, reply_d;
  logic [REPLY_BIT_NUM-1:0]   lock_q, lock_d;
  logic                       lock_valid_q, lock_valid_d;
  logic                       ready_q, ready_d;
  logic                       sclk_q, sclk_d;
  logic                       cs_q, cs_d;
  logic                       mosi_q, mosi_d;
  logic                       timer_load, timer_done;
  logic [TW-1:0]              timer_val;

  spi_cmd_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    read_d       = read_q;
    shreg_d      = shreg_q;
    reply_d      = reply_q;
    lock_d       = lock_q;
    lock_valid_d = 1'b0;

    case (state_q)
      IDLE: if (ready_q && req_valid) begin
        state_d   = CS_SETUP;
        read_d    = req_read;
        bit_cnt_d = '0;
        shreg_d   = req_read ? {READ_OPCODE, {(SHIFT_W - OPCODE_BITS){1'b0}}}
                             : {1'b0, req_data};
      end
      CS_SETUP: if (timer_done) state_d = LOW;
      LOW: if (timer_done) begin
        state_d   = HIGH;
        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
        // Rising edges 5..10 carry reply bits 0..5; the slave shifts LSB first.
        if (read_q && bit_cnt_q >= REPLY_START) begin
          reply_d = {spi_miso, reply_q[REPLY_BIT_NUM-1:1]};
        end
      end
      HIGH: if (timer_done) begin
        if (bit_cnt_q == (read_q ? READ_LAST : WRITE_LAST)) begin
          state_d = TAIL;
        end else begin
          state_d = LOW;
          shreg_d = {shreg_q[SHIFT_W-2:0], 1'b0};
        end
      end
      TAIL: if (timer_done) begin
        state_d = CS_HOLD;
        if (read_q) begin
          lock_d       = reply_q;
          lock_valid_d = 1'b1;
        end
      end
      CS_HOLD: if (timer_done) state_d = CS_GAP;
      CS_GAP:  if (timer_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Pins are registered from the next state so they switch cleanly with it.
    mosi_d  = (state_d inside {CS_SETUP, LOW, HIGH}) ? shreg_d[SHIFT_W-1] : 1'b0;
    sclk_d  = (state_d == HIGH);
    cs_d    = !(state_d inside {CS_SETUP, LOW, HIGH, TAIL, CS_HOLD});
    ready_d = (state_d == IDLE);

    timer_load = (state_d != state_q);
    case (state_d)
      IDLE:    timer_val = '0;
      CS_HOLD: timer_val = TW'(CS_HOLD_CYC - 1);
      CS_GAP:  timer_val = TW'(CS_IDLE_CYC - 1);
      default: timer_val = TW'(CLK_DIV - 1);
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      read_q       <= 1'b0;
      lock_q       <= '0;
      lock_valid_q <= 1'b0;
      ready_q      <= 1'b0;
      sclk_q       <= 1'b0;
      cs_q         <= 1'b1;
      mosi_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      read_q       <= read_d;
      lock_q       <= lock_d;
      lock_valid_q <= lock_valid_d;
      ready_q      <= ready_d;
      sclk_q       <= sclk_d;
      cs_q         <= cs_d;
      mosi_q       <= mosi_d;
    end
  end

  // NOTE: the shifters carry no reset; they are always reloaded or fully
  // refilled before their contents reach a pin or lock_status.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
    reply_q <= reply_d;
  end

  assign req_ready   = ready_q;
  assign lock_status = lock_q;
  assign lock_valid  = lock_valid_q;
  assign busy        = (state_q != IDLE);
  assign spi_clk     = sclk_q;
  assign spi_cs      = cs_q;
  assign spi_mosi    = mosi_q;

endmodule

// File: tb/tb_spi_cmd_master.sv
// Bench for spi_cmd_master: frame-timing model checked every cycle, a pin-level
// slave model, directed frames, and a CLK_DIV=2 instance for timing.
module tb_spi_cmd_master;

  localparam int D = 4;
  localparam int H = 16;
  localparam int I = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0, req_read = 1'b0;
  logic [40:0] req_data = '0;
  logic        req_ready, lock_valid, busy, spi_clk, spi_cs, spi_mosi;
  logic [5:0]  lock_status;
  logic        spi_miso = 1'b0;

  logic        req_valid2 = 1'b0;
  logic [40:0] req_data2 = '0;
  logic        req_ready2, lock_valid2, busy2, spi_clk2, spi_cs2, spi_mosi2;
  logic [5:0]  lock_status2;

  spi_cmd_master #(.CLK_DIV(D), .CS_HOLD_CYC(H), .CS_IDLE_CYC(I)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_read(req_read),
    .req_data(req_data), .req_ready(req_ready), .lock_status(lock_status),
    .lock_valid(lock_valid), .busy(busy), .spi_clk(spi_clk), .spi_cs(spi_cs),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  spi_cmd_master #(.CLK_DIV(2), .CS_HOLD_CYC(H), .CS_IDLE_CYC(I)) u_dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid2), .req_read(1'b0),
    .req_data(req_data2), .req_ready(req_ready2), .lock_status(lock_status2),
    .lock_valid(lock_valid2), .busy(busy2), .spi_clk(spi_clk2), .spi_cs(spi_cs2),
    .spi_mosi(spi_mosi2), .spi_miso(1'b0)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pin-level slave: shifts MOSI on rising spi_clk, enters reply mode on opcode 1000.
  logic [5:0]  pll = '0;
  int          s_cnt = 0, s_last_cnt = 0, s_frames = 0;
  logic [41:0] s_cap = '0, s_last_cap = '0;
  bit          s_reply = 1'b0, s_last_reply = 1'b0;
  logic        s_prev_clk = 1'b0, s_prev_cs = 1'b1;

  always @(spi_clk, spi_cs) begin
    if (spi_cs === 1'b1 && s_prev_cs === 1'b0) begin
      s_last_cnt   = s_cnt;
      s_last_cap   = s_cap;
      s_last_reply = s_reply;
      s_frames++;
      s_cnt   = 0;
      s_cap   = '0;
      s_reply = 1'b0;
      spi_miso = 1'b0;
    end else if (spi_cs === 1'b0 && spi_clk === 1'b1 && s_prev_clk === 1'b0) begin
      s_cap = {s_cap[40:0], spi_mosi};
      s_cnt++;
      if (s_cnt == 4 && s_cap[3:0] == 4'b1000) s_reply = 1'b1;
    end else if (spi_cs === 1'b0 && spi_clk === 1'b0 && s_prev_clk === 1'b1) begin
      if (s_reply && s_cnt >= 4 && s_cnt < 10) spi_miso = pll[s_cnt-4];
    end
    s_prev_clk = spi_clk;
    s_prev_cs  = spi_cs;
  end

  // Frame model: m_t counts cycles since acceptance (0 = idle).
  int         m_t = 0, m_n = 42;
  bit         m_read = 1'b0, m_jr = 1'b0, m_started = 1'b0, m_rdy;
  bit         m_bits [0:41];
  logic [5:0] m_lock = '0;

  function automatic int act_len(input int n);
    return D * (2 * n + 2);
  endfunction

  initial forever begin
    @(posedge clk);
    if (!rst) begin
      m_t = 0; m_lock = '0; m_jr = 1'b1; m_started = 1'b1;
    end else if (m_started) begin
      m_rdy = (m_t == 0) && !m_jr;
      m_jr  = 1'b0;
      if (m_t != 0) begin
        if (m_read && m_t == act_len(m_n)) m_lock = pll;
        m_t = (m_t == act_len(m_n) + H + I) ? 0 : m_t + 1;
      end else if (m_rdy && req_valid) begin
        m_t    = 1;
        m_read = req_read;
        m_n    = req_read ? 10 : 42;
        for (int i = 0; i < 42; i++) begin
          if (req_read)    m_bits[i] = (i == 0);
          else if (i == 0) m_bits[i] = 1'b0;
          else             m_bits[i] = req_data[41-i];
        end
      end
    end
  end

  // Compare process plus monitors for lock_valid, cs gaps and dut2 half periods.
  logic e_cs, e_sclk, e_mosi, e_busy, e_ready, e_lv;
  int   e_a, e_p;
  int   lv_total = 0, run_cs = 0, last_gap = 0;
  bit   had_low = 1'b0;
  logic p2_clk = 1'b0;
  int   run2 = 0, hp_min = 1000, hp_max = 0;
  bit   bnd2 = 1'b0;

  initial forever begin
    @(negedge clk);
    if (m_started) begin
      e_cs = 1'b1; e_sclk = 1'b0; e_mosi = 1'b0; e_busy = 1'b0; e_ready = !m_jr; e_lv = 1'b0;
      if (m_t != 0) begin
        e_a = act_len(m_n);
        e_p = m_t - 1 - D;
        e_cs = (m_t > e_a + H);
        e_busy = 1'b1;
        e_ready = 1'b0;
        if (e_p >= 0 && e_p < 2 * m_n * D) begin
          e_sclk = ((e_p / D) % 2) == 1;
          e_mosi = m_bits[e_p / (2 * D)];
        end
        if (m_t <= D) e_mosi = m_bits[0];
        e_lv = m_read && (m_t == e_a + 1);
      end
      check("outputs", {spi_cs, spi_clk, spi_mosi, busy, req_ready, lock_valid, lock_status},
            {e_cs, e_sclk, e_mosi, e_busy, e_ready, e_lv, m_lock});
      if (lock_valid === 1'b1) lv_total++;
      if (spi_cs === 1'b0) begin
        if (had_low && run_cs > 0) last_gap = run_cs;
        had_low = 1'b1;
        run_cs = 0;
      end else begin
        run_cs++;
      end
    end
    if (spi_cs2 !== 1'b0) begin
      bnd2 = 1'b0; run2 = 0; p2_clk = 1'b0;
    end else if (spi_clk2 !== p2_clk) begin
      if (bnd2) begin
        if (run2 < hp_min) hp_min = run2;
        if (run2 > hp_max) hp_max = run2;
      end
      bnd2 = 1'b1; run2 = 1; p2_clk = spi_clk2;
    end else begin
      run2++;
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (req_ready !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("wait_ready", req_ready, 1);
  endtask

  task automatic do_frame(input logic rd, input logic [40:0] data);
    wait_ready();
    req_valid = 1'b1; req_read = rd; req_data = data;
    @(negedge clk);
    req_valid = 1'b0;
    wait_ready();
  endtask

  int lv0, f0, n;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_cs", spi_cs, 1);
    check("rst_sclk", spi_clk, 0);
    check("rst_mosi", spi_mosi, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", req_ready, 0);
    check("rst_lock", {lock_valid, lock_status}, 0);
    rst = 1'b1;

    // Write 0x155_5555_5555: pad then alternating bits.
    pll = 6'b101101;
    lv0 = lv_total;
    do_frame(1'b0, 41'h155_5555_5555);
    check("w1_edges", s_last_cnt, 42);
    check("w1_first_bits", s_last_cap[41:38], 4'b0101);
    check("w1_word", s_last_cap[40:0], 41'h155_5555_5555);
    check("w1_no_reply", s_last_reply, 0);
    check("w1_no_lv", lv_total - lv0, 0);

    // Status read returning 101101.
    lv0 = lv_total;
    do_frame(1'b1, '0);
    check("r1_edges", s_last_cnt, 10);
    check("r1_mosi", s_last_cap[9:0], 10'b10_0000_0000);
    check("r1_reply_mode", s_last_reply, 1);
    check("r1_lock", lock_status, 6'b101101);
    check("r1_lv_pulses", lv_total - lv0, 1);

    // Write whose top command bits are 1000: the pad keeps it from looking like a read.
    do_frame(1'b0, 41'h100_0000_0000);
    check("w2_no_reply", s_last_reply, 0);
    check("w2_edges", s_last_cnt, 42);
    check("w2_first_bits", s_last_cap[41:38], 4'b0100);
    check("w2_word", s_last_cap[40:0], 41'h100_0000_0000);

    // Back-to-back: valid held high across read then write.
    pll = 6'b010011;
    f0 = s_frames;
    wait_ready();
    req_valid = 1'b1; req_read = 1'b1; req_data = '0;
    @(negedge clk);
    req_read = 1'b0; req_data = 41'h0AB_CDEF_1234;
    n = 0;
    while (req_ready !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("b2b_second_ready", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    wait_ready();
    check("b2b_frames", s_frames - f0, 2);
    check("b2b_lock", lock_status, 6'b010011);
    check("b2b_word", s_last_cap[40:0], 41'h0AB_CDEF_1234);
    check("b2b_write_no_reply", s_last_reply, 0);
    check("b2b_cs_gap_ok", last_gap >= I, 1);

    // Reset in the middle of a read, then a fresh read.
    pll = 6'b110001;
    wait_ready();
    req_valid = 1'b1; req_read = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (s_cnt < 3 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("mid_rst_reached_edge3", s_cnt, 3);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_cs", spi_cs, 1);
    check("mid_rst_sclk", spi_clk, 0);
    check("mid_rst_mosi", spi_mosi, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_lock", lock_status, 0);
    rst = 1'b1;
    pll = 6'b011010;
    lv0 = lv_total;
    do_frame(1'b1, '0);
    check("r2_lock", lock_status, 6'b011010);
    check("r2_lv_pulses", lv_total - lv0, 1);
    check("r2_edges", s_last_cnt, 10);

    // CLK_DIV=2 instance: half periods and acceptance-to-ready latency.
    n = 0;
    while (req_ready2 !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    req_data2 = 41'h1F0_0F0F_00FF;
    req_valid2 = 1'b1;
    @(negedge clk);
    req_valid2 = 1'b0;
    n = 1;
    while (req_ready2 !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("div2_frame_cycles", n, 197);
    check("div2_half_min", hp_min, 2);
    check("div2_half_max", hp_max, 2);

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
